regfile_sb: RTL and testbench

Parametrised, scoreboarded register file for the pipelined MIPS core, succeeding the single-cycle two-read/one-write file. It provides NREAD asynchronous read ports, one synchronous write port, a per-register busy scoreboard for hazard detection, and an optional write-to-read bypass. It sits between decode (reads, issue) and writeback (write, busy clear).

---
 rtl/regfile_pkg.sv | 30 +++
 rtl/regfile_sb_if.sv | 29 ++
 rtl/regfile_sb_sb_counter.sv | 38 +++
 rtl/regfile_sb.sv | 127 ++++++++++++
 tb/tb_regfile_sb.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file.
// Default widths, architectural register constants and the
// busy-counter operation encoding used by sb_counter.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Hard-wired zero register and MIPS return-address register.
    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    // Simultaneous increment and decrement cancel out.
    function automatic cnt_op_e cnt_op(input logic inc, input logic dec);
        cnt_op_e op;
        case ({inc, dec})
            2'b10:   op = CNT_INC;
            2'b01:   op = CNT_DEC;
            default: op = CNT_HOLD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of the scoreboarded register file.
// master = pipeline side (decode + writeback), slave = register file.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
);
    logic [NREAD*ADDR_W-1:0] ra;
    logic [NREAD*DATA_W-1:0] rd;
    logic [NREAD-1:0]        rbusy;
    logic                    we;
    logic [ADDR_W-1:0]       wa;
    logic [DATA_W-1:0]       wd;
    logic                    wclr;
    logic                    iss_valid;
    logic [ADDR_W-1:0]       iss_addr;
    logic                    iss_ready;
    logic [ADDR_W:0]         busy_cnt;

    modport master (
        output ra, we, wa, wd, wclr, iss_valid, iss_addr,
        input  rd, rbusy, iss_ready, busy_cnt
    );

    modport slave (
        input  ra, we, wa, wd, wclr, iss_valid, iss_addr,
        output rd, rbusy, iss_ready, busy_cnt
    );
endinterface

// File: rtl/regfile_sb_sb_counter.sv
// Up/down counter tracking the number of busy registers.
// An increment and a decrement in the same cycle leave the count unchanged.
module sb_counter
    import regfile_pkg::*;
#(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt
);

    cnt_op_e      w_op;
    logic [W-1:0] r_cnt;

    // Resolve the requested counter operation.
    always_comb begin
        w_op = cnt_op(i_inc, i_dec);
    end

    // Busy counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            case (w_op)
                CNT_INC: r_cnt <= r_cnt + W'(1);
                CNT_DEC: r_cnt <= r_cnt - W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/regfile_sb.sv
// Scoreboarded register file: NREAD combinational read ports, one
// synchronous write port, per-register busy bits with an issue handshake
// and a registered busy counter.
// Optional feature macro: RF_BYPASS_EN (same-cycle write-to-read forwarding).
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREAD  = 2
) (
    input  logic         clk,
    input  logic         reset,
    regfile_sb_if.slave  rf
);

    localparam int                DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] A_ZERO = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;

    logic              w_wr_en;
    logic              w_clr_en;
    logic              w_iss_ready;
    logic              w_set_en;
    logic              w_inc;
    logic              w_dec;
    logic [ADDR_W:0]   w_cnt;

    // Write/clear qualification, issue handshake and counter events.
    always_comb begin
        w_wr_en  = rf.we && (rf.wa != A_ZERO);
        w_clr_en = w_wr_en && rf.wclr;

        if (!rf.iss_valid) begin
            w_iss_ready = 1'b0;
        end else if (rf.iss_addr == A_ZERO) begin
            w_iss_ready = 1'b1;
        end else if (!r_busy[rf.iss_addr]) begin
            w_iss_ready = 1'b1;
        end else if (rf.we && rf.wclr && (rf.wa == rf.iss_addr)) begin
            // Writeback releasing the very register being issued.
            w_iss_ready = 1'b1;
        end else begin
            w_iss_ready = 1'b0;
        end

        w_set_en = w_iss_ready && (rf.iss_addr != A_ZERO);
        // Count only real transitions; a re-issue of a register cleared in
        // the same cycle keeps it busy, so neither event moves the count.
        w_inc    = w_set_en && !r_busy[rf.iss_addr];
        w_dec    = w_clr_en && r_busy[rf.wa] &&
                   !(w_set_en && (rf.iss_addr == rf.wa));
    end

    assign rf.iss_ready = w_iss_ready;

    // Register storage; entry 0 is never written and stays zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_regs[k] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[rf.wa] <= rf.wd;
        end
    end

    // Busy scoreboard; the set is applied last so an issue beats a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            if (w_clr_en) begin
                r_busy[rf.wa] <= 1'b0;
            end
            if (w_set_en) begin
                r_busy[rf.iss_addr] <= 1'b1;
            end
        end
    end

    sb_counter #(
        .W (ADDR_W + 1)
    ) u_sb_counter (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_inc),
        .i_dec (w_dec),
        .o_cnt (w_cnt)
    );

    assign rf.busy_cnt = w_cnt;

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;
        logic              w_rbusy;

        assign w_ra = rf.ra[gi*ADDR_W +: ADDR_W];

        // Combinational read of one port, with optional write forwarding.
        always_comb begin
            w_rd    = '0;
            w_rbusy = 1'b0;
            if (w_ra == A_ZERO) begin
                w_rd    = '0;
                w_rbusy = 1'b0;
            end
`ifdef RF_BYPASS_EN
            else if (w_wr_en && (w_ra == rf.wa)) begin
                w_rd    = rf.wd;
                w_rbusy = rf.wclr ? 1'b0 : r_busy[w_ra];
            end
`endif
            else begin
                w_rd    = r_regs[w_ra];
                w_rbusy = r_busy[w_ra];
            end
        end

        assign rf.rd[gi*DATA_W +: DATA_W] = w_rd;
        assign rf.rbusy[gi]               = w_rbusy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (two read ports, 32x32).
module tb_regfile_sb;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) rf ();

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .rf    (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf.we        = 1'b0;
        rf.wa        = 5'd0;
        rf.wd        = 32'd0;
        rf.wclr      = 1'b0;
        rf.iss_valid = 1'b0;
        rf.iss_addr  = 5'd0;
    endtask

    task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
        rf.ra = {a1, a0};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        set_ra(5'd0, 5'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        for (int a = 0; a < 32; a++) begin
            set_ra(5'(a), 5'(31 - a));
            #1;
            n_cmp++;
            if (rf.rd !== 64'd0 || rf.rbusy !== 2'b00) begin
                n_err++;
                $display("FAIL reset_read a=%0d: rd=%h rbusy=%b want 0/00", a, rf.rd, rf.rbusy);
            end
        end
        n_cmp++;
        if (rf.busy_cnt !== 6'd0) begin
            n_err++;
            $display("FAIL reset_cnt: got %0d want 0", rf.busy_cnt);
        end
        rf.iss_valid = 1'b1;
        rf.iss_addr  = 5'd3;
        #1;
        n_cmp++;
        if (rf.iss_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_iss_ready: got %b want 1", rf.iss_ready);
        end
        idle();
        #1;
        n_cmp++;
        if (rf.iss_ready !== 1'b0) begin
            n_err++;
            $display("FAIL idle_iss_ready: got %b want 0", rf.iss_ready);
        end
    endtask

    task automatic test_write_read();
        set_ra(5'd5, 5'd0);
        rf.we = 1'b1;
        rf.wa = 5'd5;
        rf.wd = 32'hDEADBEEF;
        #1;
        n_cmp++;
`ifdef RF_BYPASS_EN
        if (rf.rd[31:0] !== 32'hDEADBEEF) begin
`else
        if (rf.rd[31:0] !== 32'h0) begin
`endif
            n_err++;
            $display("FAIL wr_pre_edge: rd0=%h", rf.rd[31:0]);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (rf.rd[31:0] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL wr_r5: got %h want deadbeef", rf.rd[31:0]);
        end
        rf.we = 1'b1;
        rf.wa = 5'd0;
        rf.wd = 32'h1234;
        set_ra(5'd0, 5'd5);
        tick();
        idle();
        #1;
        n_cmp++;
        if (rf.rd[31:0] !== 32'h0 || rf.rd[63:32] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL wr_r0: rd0=%h rd1=%h want 0/deadbeef", rf.rd[31:0], rf.rd[63:32]);
        end
    endtask

    task automatic test_issue_conflict();
        set_ra(5'd7, 5'd0);
        rf.iss_valid = 1'b1;
        rf.iss_addr  = 5'd7;
        #1;
        n_cmp++;
        if (rf.iss_ready !== 1'b1) begin
            n_err++;
            $display("FAIL iss7_first: got %b want 1", rf.iss_ready);
        end
        tick();
        n_cmp++;
        if (rf.iss_ready !== 1'b0 || rf.rbusy[0] !== 1'b1 || rf.busy_cnt !== 6'd1) begin
            n_err++;
            $display("FAIL iss7_second: ready=%b rbusy=%b cnt=%0d want 0/1/1",
                     rf.iss_ready, rf.rbusy[0], rf.busy_cnt);
        end
        rf.we   = 1'b1;
        rf.wa   = 5'd7;
        rf.wd   = 32'h77;
        rf.wclr = 1'b1;
        #1;
        n_cmp++;
        if (rf.iss_ready !== 1'b1) begin
            n_err++;
            $display("FAIL iss7_with_clr: got %b want 1", rf.iss_ready);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (rf.rbusy[0] !== 1'b1 || rf.busy_cnt !== 6'd1 || rf.rd[31:0] !== 32'h77) begin
            n_err++;
            $display("FAIL clr_iss_same: rbusy=%b cnt=%0d rd=%h want 1/1/77",
                     rf.rbusy[0], rf.busy_cnt, rf.rd[31:0]);
        end
        rf.we   = 1'b1;
        rf.wa   = 5'd7;
        rf.wd   = 32'h78;
        rf.wclr = 1'b1;
        tick();
        idle();
        #1;
        n_cmp++;
        if (rf.rbusy[0] !== 1'b0 || rf.busy_cnt !== 6'd0) begin
            n_err++;
            $display("FAIL clr7: rbusy=%b cnt=%0d want 0/0", rf.rbusy[0], rf.busy_cnt);
        end
    endtask

    task automatic test_busy_count();
        logic [5:0] exp_cnt [3];
        exp_cnt = '{6'd1, 6'd2, 6'd3};
        for (int i = 0; i < 3; i++) begin
            rf.iss_valid = 1'b1;
            rf.iss_addr  = 5'(i + 1);
            tick();
            n_cmp++;
            if (rf.busy_cnt !== exp_cnt[i]) begin
                n_err++;
                $display("FAIL cnt_issue r%0d: got %0d want %0d", i + 1, rf.busy_cnt, exp_cnt[i]);
            end
        end
        idle();
        for (int i = 0; i < 2; i++) begin
            rf.we   = 1'b1;
            rf.wa   = 5'd2;
            rf.wclr = 1'b1;
            tick();
            n_cmp++;
            if (rf.busy_cnt !== 6'd2) begin
                n_err++;
                $display("FAIL cnt_clr_r2 pass%0d: got %0d want 2", i, rf.busy_cnt);
            end
        end
        idle();
        set_ra(5'd2, 5'd3);
        #1;
        n_cmp++;
        if (rf.rbusy !== 2'b10) begin
            n_err++;
            $display("FAIL rbusy_r2_r3: got %b want 10", rf.rbusy);
        end
        // Issue r4 while clearing r1: count holds at 2.
        rf.iss_valid = 1'b1;
        rf.iss_addr  = 5'd4;
        rf.we        = 1'b1;
        rf.wa        = 5'd1;
        rf.wclr      = 1'b1;
        tick();
        idle();
        set_ra(5'd1, 5'd4);
        #1;
        n_cmp++;
        if (rf.busy_cnt !== 6'd2 || rf.rbusy !== 2'b10) begin
            n_err++;
            $display("FAIL inc_dec_same_cycle: cnt=%0d rbusy=%b want 2/10", rf.busy_cnt, rf.rbusy);
        end
        // Issue to r0 is accepted but changes nothing.
        rf.iss_valid = 1'b1;
        rf.iss_addr  = 5'd0;
        #1;
        n_cmp++;
        if (rf.iss_ready !== 1'b1) begin
            n_err++;
            $display("FAIL iss_r0_ready: got %b want 1", rf.iss_ready);
        end
        tick();
        idle();
        set_ra(5'd0, 5'd0);
        #1;
        n_cmp++;
        if (rf.busy_cnt !== 6'd2 || rf.rbusy !== 2'b00) begin
            n_err++;
            $display("FAIL iss_r0_effect: cnt=%0d rbusy=%b want 2/00", rf.busy_cnt, rf.rbusy);
        end
        for (int i = 3; i < 5; i++) begin
            rf.we   = 1'b1;
            rf.wa   = 5'(i);
            rf.wclr = 1'b1;
            tick();
        end
        idle();
        #1;
        n_cmp++;
        if (rf.busy_cnt !== 6'd0) begin
            n_err++;
            $display("FAIL cnt_drain: got %0d want 0", rf.busy_cnt);
        end
    endtask

    task automatic test_bypass();
        rf.we        = 1'b1;
        rf.wa        = 5'd9;
        rf.wd        = 32'h11;
        rf.iss_valid = 1'b1;
        rf.iss_addr  = 5'd9;
        tick();
        idle();
        set_ra(5'd0, 5'd9);
        rf.we   = 1'b1;
        rf.wa   = 5'd9;
        rf.wd   = 32'h55;
        rf.wclr = 1'b1;
        #1;
        n_cmp++;
`ifdef RF_BYPASS_EN
        if (rf.rd[63:32] !== 32'h55 || rf.rbusy[1] !== 1'b0) begin
            n_err++;
            $display("FAIL bypass_same_cycle: rd1=%h rbusy1=%b want 55/0", rf.rd[63:32], rf.rbusy[1]);
        end
`else
        if (rf.rd[63:32] !== 32'h11 || rf.rbusy[1] !== 1'b1) begin
            n_err++;
            $display("FAIL nobypass_same_cycle: rd1=%h rbusy1=%b want 11/1", rf.rd[63:32], rf.rbusy[1]);
        end
`endif
        tick();
        idle();
        #1;
        n_cmp++;
        if (rf.rd[63:32] !== 32'h55 || rf.rbusy[1] !== 1'b0 || rf.busy_cnt !== 6'd0) begin
            n_err++;
            $display("FAIL bypass_after_edge: rd1=%h rbusy1=%b cnt=%0d want 55/0/0",
                     rf.rd[63:32], rf.rbusy[1], rf.busy_cnt);
        end
    endtask

    task automatic test_async_reset();
        rf.we        = 1'b1;
        rf.wa        = 5'd4;
        rf.wd        = 32'hAA;
        rf.iss_valid = 1'b1;
        rf.iss_addr  = 5'd4;
        tick();
        idle();
        set_ra(5'd4, 5'd5);
        #1;
        n_cmp++;
        if (rf.rd[31:0] !== 32'hAA || rf.rbusy !== 2'b01 || rf.busy_cnt !== 6'd1) begin
            n_err++;
            $display("FAIL pre_reset: rd0=%h rbusy=%b cnt=%0d want aa/01/1",
                     rf.rd[31:0], rf.rbusy, rf.busy_cnt);
        end
        rf.iss_valid = 1'b1;
        rf.iss_addr  = 5'd4;
        #1;
        n_cmp++;
        if (rf.iss_ready !== 1'b0) begin
            n_err++;
            $display("FAIL pre_reset_ready: got %b want 0", rf.iss_ready);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (rf.rd !== 64'd0 || rf.rbusy !== 2'b00 || rf.busy_cnt !== 6'd0 || rf.iss_ready !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset: rd=%h rbusy=%b cnt=%0d ready=%b want 0/00/0/1",
                     rf.rd, rf.rbusy, rf.busy_cnt, rf.iss_ready);
        end
        idle();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_write_read();
        test_issue_conflict();
        test_busy_count();
        test_bypass();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
